// File: rtl/rggen_axi4lite_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to APB bridge.
//   bridge_state_e : bridge FSM states (IDLE/SETUP/ACCESS/RESP)
//   grant_kind_e   : kind of request being served (WRITE/READ)
//   OKAY / SLVERR  : AXI response encodings
package rggen_axi4lite_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } bridge_state_e;

  typedef enum logic {
    WRITE,
    READ
  } grant_kind_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/rggen_axi4lite_hold_slot.sv
// One-entry hold register for an AXI channel.
// Handshake: the channel transfers when valid && ready at a rising clk edge;
// ready is high exactly while the slot is empty, and the payload is captured
// on that edge. The slot stays full until consume is pulsed.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   valid/ready: upstream handshake, data: upstream payload
//   consume    : empties the slot (only pulsed while full)
//   full, q    : slot occupancy and held payload
module rggen_axi4lite_hold_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  output logic             ready,
  input  logic [WIDTH-1:0] data,
  input  logic             consume,
  output logic             full,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full <= 1'b0;
      q    <= '0;
    end else if (consume) begin
      full <= 1'b0;
    end else if (valid && !full) begin
      full <= 1'b1;
      q    <= data;
    end
  end

  assign ready = !full;

endmodule

// File: rtl/rggen_axi4lite_apb_bridge.sv
// AXI4-Lite slave to APB master bridge.
// AW, W and AR are buffered in one-entry hold slots and serialised into single
// APB transfers, one at a time. When a write (AW+W) and a read (AR) are both
// waiting, the kind not served last wins. B/R responses map pslverr to SLVERR;
// an optional ACCESS-phase timeout aborts a transfer with SLVERR.
// All AXI/APB handshakes follow valid/ready semantics: a beat transfers on the
// rising clk edge where both valid and ready are high; valid holds its payload
// stable until then.
// Ports:
//   clk, rst_n                       : clock, synchronous active-low reset
//   aw*/w*/ar*                       : AXI4-Lite request channels
//   b*/r*                            : AXI4-Lite response channels
//   psel/penable/pwrite/paddr/pwdata/pstrb : APB master request
//   pready/pslverr/prdata            : APB completion
module rggen_axi4lite_apb_bridge
  import rggen_axi4lite_bridge_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 32,  // 32 or 64
  parameter int TIMEOUT_CYCLES = 0    // 0 disables the timeout
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [ADDRESS_WIDTH-1:0]  awaddr,
  input  logic                      wvalid,
  output logic                      wready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  output logic                      bvalid,
  input  logic                      bready,
  output logic [1:0]                bresp,
  input  logic                      arvalid,
  output logic                      arready,
  input  logic [ADDRESS_WIDTH-1:0]  araddr,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDRESS_WIDTH-1:0]  paddr,
  output logic [DATA_WIDTH-1:0]     pwdata,
  output logic [DATA_WIDTH/8-1:0]   pstrb,
  input  logic                      pready,
  input  logic                      pslverr,
  input  logic [DATA_WIDTH-1:0]     prdata
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  // The counter only needs to reach TIMEOUT_CYCLES-1: the abort fires on the
  // ACCESS cycle that would have made it TIMEOUT_CYCLES.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST =
    TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  bridge_state_e                  state;
  bridge_state_e                  state_next;
  grant_kind_e                    kind;       // kind in flight / served last
  logic [1:0]                     resp_q;
  logic [TW-1:0]                  tmo_cnt;

  logic                           aw_full;
  logic [ADDRESS_WIDTH-1:0]       aw_addr_q;
  logic                           w_full;
  logic [STRB_WIDTH+DATA_WIDTH-1:0] w_q;
  logic                           ar_full;
  logic [ADDRESS_WIDTH-1:0]       ar_addr_q;

  logic                           grant_write;
  logic                           grant_read;
  logic                           access_done;
  logic                           access_abort;
  logic                           write_ok;
  logic                           read_ok;

  rggen_axi4lite_hold_slot #(.WIDTH(ADDRESS_WIDTH)) u_aw_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (awvalid),
    .ready   (awready),
    .data    (awaddr),
    .consume (grant_write),
    .full    (aw_full),
    .q       (aw_addr_q)
  );

  rggen_axi4lite_hold_slot #(.WIDTH(STRB_WIDTH + DATA_WIDTH)) u_w_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (wvalid),
    .ready   (wready),
    .data    ({wstrb, wdata}),
    .consume (grant_write),
    .full    (w_full),
    .q       (w_q)
  );

  rggen_axi4lite_hold_slot #(.WIDTH(ADDRESS_WIDTH)) u_ar_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (arvalid),
    .ready   (arready),
    .data    (araddr),
    .consume (grant_read),
    .full    (ar_full),
    .q       (ar_addr_q)
  );

  assign write_ok = aw_full && w_full;
  assign read_ok  = ar_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    grant_write  = 1'b0;
    grant_read   = 1'b0;
    access_done  = 1'b0;
    access_abort = 1'b0;
    case (state)
      IDLE: begin
        if (write_ok && read_ok) begin
          // kind resets to READ so the first tie goes to the write
          if (kind == WRITE) grant_read  = 1'b1;
          else               grant_write = 1'b1;
        end else if (write_ok) begin
          grant_write = 1'b1;
        end else if (read_ok) begin
          grant_read = 1'b1;
        end
        if (grant_write || grant_read) state_next = SETUP;
      end
      SETUP: state_next = ACCESS;
      ACCESS: begin
        if (pready) begin
          access_done = 1'b1;
          state_next  = RESP;
        end else if ((TIMEOUT_CYCLES > 0) && (tmo_cnt == TMO_LAST)) begin
          access_abort = 1'b1;
          state_next   = RESP;
        end
      end
      RESP: begin
        if ((kind == WRITE && bready) || (kind == READ && rready)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // APB request fields are loaded only on a grant, so they stay stable through
  // SETUP/ACCESS even when the slots refill behind them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kind    <= READ;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      pstrb   <= '0;
      resp_q  <= OKAY;
      rdata   <= '0;
      tmo_cnt <= '0;
    end else begin
      if (grant_write) begin
        kind    <= WRITE;
        pwrite  <= 1'b1;
        paddr   <= aw_addr_q;
        pwdata  <= w_q[DATA_WIDTH-1:0];
        pstrb   <= w_q[STRB_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
        tmo_cnt <= '0;
      end else if (grant_read) begin
        kind    <= READ;
        pwrite  <= 1'b0;
        paddr   <= ar_addr_q;
        pwdata  <= '0;
        pstrb   <= '0;
        tmo_cnt <= '0;
      end
      if (access_done) begin
        resp_q <= pslverr ? SLVERR : OKAY;
        if (kind == READ) rdata <= prdata;
      end else if (access_abort) begin
        resp_q <= SLVERR;
        rdata  <= '0;
      end else if (state == ACCESS) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  assign psel    = (state == SETUP) || (state == ACCESS);
  assign penable = (state == ACCESS);
  assign bvalid  = (state == RESP) && (kind == WRITE);
  assign rvalid  = (state == RESP) && (kind == READ);
  assign bresp   = resp_q;
  assign rresp   = resp_q;

endmodule

// File: tb/tb_rggen_axi4lite_apb_bridge.sv
`timescale 1ns/1ps
module tb_rggen_axi4lite_apb_bridge;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 8;
  localparam logic [AW-1:0] ERR_ADDR = 16'h007C;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr, paddr;
  logic [DW-1:0] wdata, rdata, pwdata, prdata;
  logic [SW-1:0] wstrb, pstrb;
  logic [1:0]    bresp, rresp;
  logic          psel, penable, pwrite, pready, pslverr;

  rggen_axi4lite_apb_bridge #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } apb_t;

  apb_t          exp_apb_q[$];
  logic [1:0]    exp_b_q[$];
  logic [DW+1:0] exp_r_q[$];   // {resp, data}
  logic [DW-1:0] ref_mem[32];  // reference register file
  logic [DW-1:0] apb_mem[32];  // contents of the modelled APB slave

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- APB slave model + APB monitor ----------------
  bit stall = 0;
  int forced_wait = -1;
  int wait_target = 0, wait_cnt = 0, access_run = 0;
  int last_access_run = 0, last_setup_cyc = -1, first_access_cyc = -1, setup_count = 0;
  apb_t snap;
  bit stable;

  initial begin
    apb_t e;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pready = 1'b0;
        access_run = 0;
        continue;
      end
      if (psel && !penable) begin
        setup_count++;
        last_setup_cyc = cyc;
        snap = {pwrite, paddr, pwdata, pstrb};
        stable = 1'b1;
        wait_cnt = 0;
        access_run = 0;
        wait_target = stall ? 1000000 : (forced_wait >= 0 ? forced_wait : $urandom_range(0, 4));
        pready = 1'b0;
        pslverr = 1'b0;
      end else if (psel && penable) begin
        if (access_run == 0) first_access_cyc = cyc;
        access_run++;
        last_access_run = access_run;
        if (snap != {pwrite, paddr, pwdata, pstrb}) stable = 1'b0;
        if (wait_cnt < wait_target) begin
          // junk on the completion signals must be ignored while pready is low
          wait_cnt++;
          pready  = 1'b0;
          pslverr = 1'($urandom_range(0, 1));
          prdata  = $urandom;
        end else begin
          pready  = 1'b1;
          pslverr = (paddr == ERR_ADDR);
          prdata  = apb_mem[paddr[6:2]];
          chk("apb_stable", 64'(stable), 64'(1));
          chk("apb_expected", 64'(exp_apb_q.size() > 0), 64'(1));
          if (exp_apb_q.size() > 0) begin
            e = exp_apb_q.pop_front();
            chk("apb_pwrite", 64'(pwrite), 64'(e.write));
            chk("apb_paddr", 64'(paddr), 64'(e.addr));
            chk("apb_pwdata", 64'(pwdata), 64'(e.data));
            chk("apb_pstrb", 64'(pstrb), 64'(e.strb));
          end
          if (pwrite && paddr != ERR_ADDR)
            for (int b = 0; b < SW; b++)
              if (pstrb[b]) apb_mem[paddr[6:2]][8*b +: 8] = pwdata[8*b +: 8];
        end
      end else begin
        pready = 1'b0;
      end
    end
  end

  // ---------------- B/R response monitor ----------------
  bit bready_mode = 1;
  int last_rsp_cyc = -1;
  bit prev_bv = 0, prev_rv = 0;
  logic [1:0]    hold_b;
  logic [DW+1:0] hold_r;

  initial begin
    logic [DW+1:0] er;
    bready = 1'b0; rready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bready = 1'b0; rready = 1'b0; prev_bv = 0; prev_rv = 0;
        continue;
      end
      bready = bready_mode ? 1'b1 : ($urandom_range(0, 2) != 0);
      rready = bready_mode ? 1'b1 : ($urandom_range(0, 2) != 0);
      if ((bvalid && !prev_bv) || (rvalid && !prev_rv)) begin
        last_rsp_cyc = cyc;
        chk("psel_low_in_resp", 64'(psel), 64'(0));
      end
      if (bvalid && prev_bv) chk("bresp_stable", 64'(bresp), 64'(hold_b));
      if (rvalid && prev_rv) chk("rdata_stable", 64'({rresp, rdata}), 64'(hold_r));
      if (bvalid && bready) begin
        chk("b_expected", 64'(exp_b_q.size() > 0), 64'(1));
        if (exp_b_q.size() > 0) chk("bresp", 64'(bresp), 64'(exp_b_q.pop_front()));
      end
      if (rvalid && rready) begin
        chk("r_expected", 64'(exp_r_q.size() > 0), 64'(1));
        if (exp_r_q.size() > 0) begin
          er = exp_r_q.pop_front();
          chk("rresp_rdata", 64'({rresp, rdata}), 64'(er));
        end
      end
      prev_bv = bvalid; prev_rv = rvalid;
      hold_b = bresp; hold_r = {rresp, rdata};
    end
  end

  // ---------------- reference model: expectations ----------------
  task automatic expect_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    apb_t e;
    bit err;
    err = (a == ERR_ADDR);
    e.write = 1'b1; e.addr = a; e.data = d; e.strb = s;
    exp_apb_q.push_back(e);
    exp_b_q.push_back(err ? 2'b10 : 2'b00);
    if (!err)
      for (int b = 0; b < SW; b++)
        if (s[b]) ref_mem[a[6:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic expect_read(input logic [AW-1:0] a);
    apb_t e;
    e.write = 1'b0; e.addr = a; e.data = '0; e.strb = '0;
    exp_apb_q.push_back(e);
    exp_r_q.push_back({(a == ERR_ADDR) ? 2'b10 : 2'b00, ref_mem[a[6:2]]});
  endtask

  // ---------------- drivers ----------------
  task automatic send_aw(input logic [AW-1:0] a, input int dly, output int hs);
    hs = -1;
    repeat (dly) @(negedge clk);
    @(negedge clk);
    awvalid = 1'b1; awaddr = a;
    for (int i = 0; i < 300; i++) begin
      if (awready) begin hs = cyc; break; end
      @(negedge clk);
    end
    chk("aw_accepted", 64'(hs >= 0), 64'(1));
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [DW-1:0] d, input logic [SW-1:0] s, input int dly, output int hs);
    hs = -1;
    repeat (dly) @(negedge clk);
    @(negedge clk);
    wvalid = 1'b1; wdata = d; wstrb = s;
    for (int i = 0; i < 300; i++) begin
      if (wready) begin hs = cyc; break; end
      @(negedge clk);
    end
    chk("w_accepted", 64'(hs >= 0), 64'(1));
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [AW-1:0] a, input int dly, output int hs);
    hs = -1;
    repeat (dly) @(negedge clk);
    @(negedge clk);
    arvalid = 1'b1; araddr = a;
    for (int i = 0; i < 300; i++) begin
      if (arready) begin hs = cyc; break; end
      @(negedge clk);
    end
    chk("ar_accepted", 64'(hs >= 0), 64'(1));
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  int last_hs = 0;

  task automatic send_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                            input int daw, input int dw);
    int h1, h2;
    fork
      send_aw(a, daw, h1);
      send_w(d, s, dw, h2);
    join
    last_hs = h1;
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (exp_apb_q.size() == 0 && exp_b_q.size() == 0 && exp_r_q.size() == 0 &&
          !psel && !bvalid && !rvalid) begin
        done = 1;
        break;
      end
    end
    chk("drain", 64'(done), 64'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int h, base, saved_rsp;
    bit seen;
    logic [DW-1:0] v;
    awvalid = 0; awaddr = '0; wvalid = 0; wdata = '0; wstrb = '0; arvalid = 0; araddr = '0;
    for (int i = 0; i < 32; i++) begin
      v = $urandom;
      ref_mem[i] = v;
      apb_mem[i] = v;
    end
    ref_mem[2] = 32'h00010001;
    apb_mem[2] = 32'h00010001;

    // reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'({awready, wready, arready}), 64'(3'b111));
    chk("rst_apb_ctl", 64'({psel, penable, pwrite}), 64'(0));
    chk("rst_paddr", 64'(paddr), 64'(0));
    chk("rst_pwdata", 64'(pwdata), 64'(0));
    chk("rst_pstrb", 64'(pstrb), 64'(0));
    chk("rst_valids", 64'({bvalid, rvalid}), 64'(0));
    chk("rst_resp", 64'({bresp, rresp}), 64'(0));
    chk("rst_rdata", 64'(rdata), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // single write, minimum latency
    bready_mode = 1; forced_wait = 0;
    expect_write(16'h0004, 32'hDEADBEEF, 4'hF);
    send_write(16'h0004, 32'hDEADBEEF, 4'hF, 0, 0);
    wait_drain();
    chk("wr_setup_cycle", 64'(last_setup_cyc), 64'(last_hs + 2));
    chk("wr_access_cycle", 64'(first_access_cyc), 64'(last_hs + 3));
    chk("wr_bvalid_cycle", 64'(last_rsp_cyc), 64'(last_hs + 4));
    chk("wr_access_len", 64'(last_access_run), 64'(1));

    // single read with three wait states
    forced_wait = 3;
    expect_read(16'h0008);
    send_ar(16'h0008, 0, h);
    wait_drain();
    chk("rd_penable_len", 64'(last_access_run), 64'(4));
    chk("rd_rvalid_cycle", 64'(last_rsp_cyc), 64'(h + 7));

    // W five cycles ahead of AW
    forced_wait = 0;
    expect_write(16'h0000, 32'h12345678, 4'hF);
    base = setup_count;
    send_w(32'h12345678, 4'hF, 0, h);
    repeat (5) @(negedge clk);
    chk("w_first_no_apb", 64'(setup_count), 64'(base));
    chk("w_first_wready_low", 64'(wready), 64'(0));
    send_aw(16'h0000, 0, h);
    wait_drain();
    chk("w_first_one_xfer", 64'(setup_count), 64'(base + 1));

    // slave errors
    forced_wait = -1;
    expect_read(ERR_ADDR);
    send_ar(ERR_ADDR, 0, h);
    wait_drain();
    expect_write(ERR_ADDR, 32'hCAFEF00D, 4'hF);
    send_write(ERR_ADDR, 32'hCAFEF00D, 4'hF, 1, 0);
    wait_drain();

    // timeouts: pready never rises
    stall = 1;
    exp_b_q.push_back(2'b10);
    send_write(16'h0010, 32'h0BAD0BAD, 4'hF, 0, 2);
    wait_drain();
    chk("tmo_wr_access_len", 64'(last_access_run), 64'(TMO));
    exp_r_q.push_back({2'b10, {DW{1'b0}}});
    send_ar(16'h0014, 0, h);
    wait_drain();
    chk("tmo_rd_access_len", 64'(last_access_run), 64'(TMO));
    stall = 0;

    // reset during ACCESS drops the request
    stall = 1;
    saved_rsp = last_rsp_cyc;
    send_write(16'h0040, 32'hA5A5A5A5, 4'hF, 0, 0);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (psel && penable) begin seen = 1; break; end
    end
    chk("drop_reached_access", 64'(seen), 64'(1));
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("drop_apb_ctl", 64'({psel, penable}), 64'(0));
    chk("drop_ready", 64'({awready, wready, arready}), 64'(3'b111));
    chk("drop_valids", 64'({bvalid, rvalid}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    stall = 0;
    repeat (20) @(negedge clk);
    chk("drop_no_response", 64'(last_rsp_cyc), 64'(saved_rsp));

    // arbitration: first tie after reset -> write, then alternate
    for (int k = 0; k < 2; k++) begin
      expect_write(16'h0020, 32'h11110000 + 32'(k), 4'hF);
      expect_read(16'h0030);
      fork
        send_write(16'h0020, 32'h11110000 + 32'(k), 4'hF, 0, 0);
        send_ar(16'h0030, 0, h);
      join
      wait_drain();
    end
    expect_write(16'h0024, 32'h22223333, 4'h3);
    send_write(16'h0024, 32'h22223333, 4'h3, 0, 0);
    wait_drain();
    expect_read(16'h0034);          // last grant was a write -> read wins
    expect_write(16'h0028, 32'h44445555, 4'hC);
    fork
      send_write(16'h0028, 32'h44445555, 4'hC, 0, 0);
      send_ar(16'h0034, 0, h);
    join
    wait_drain();

    // back-to-back writes refill the slots while a transfer is in flight
    for (int k = 0; k < 4; k++) begin
      expect_write(16'(16'h0044 + 4 * k), $urandom, 4'hF);
      send_write(exp_apb_q[exp_apb_q.size()-1].addr, exp_apb_q[exp_apb_q.size()-1].data, 4'hF, 0, 0);
    end
    wait_drain();
    for (int k = 0; k < 4; k++) begin
      expect_read(16'(16'h0044 + 4 * k));
      send_ar(16'(16'h0044 + 4 * k), 0, h);
    end
    wait_drain();

    // randomized traffic
    bready_mode = 0; forced_wait = -1;
    for (int n = 0; n < 80; n++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [SW-1:0] s;
      a = AW'($urandom_range(0, 31) * 4);
      d = $urandom;
      s = SW'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        expect_write(a, d, s);
        send_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3));
      end else begin
        expect_read(a);
        send_ar(a, $urandom_range(0, 3), h);
      end
      wait_drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
